// File: rtl/aes_package.sv
// Shared types and constants for the AES stream packer: widths, packer FSM
// states and the status flags bundle reported to the controller.
package aes_package;

    localparam int unsigned AES_WORD_W      = 32;
    localparam int unsigned AES_BLOCK_W     = 128;
    localparam int unsigned AES_BLOCK_WORDS = 4;
    localparam int unsigned AES_CNT_W       = 16;

    typedef enum logic {
        FILL,
        FULL
    } packer_state_t;

    typedef struct packed {
        logic [1:0]           word_cnt;
        logic [AES_CNT_W-1:0] block_cnt;
        logic                 err_strb;
    } flags_packer_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Minimal HWPE stream interface: valid/ready handshake carrying data plus
// per-byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
) ();

    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);

endinterface

// File: rtl/aes_block_slot.sv
// One 128-bit block buffer: word k is written to bits 32k+31:32k, the slot
// becomes full when word 3 lands and empties on pop or clear.
module aes_block_slot
    import aes_package::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   load_i,
    input  logic [1:0]             idx_i,
    input  logic [AES_WORD_W-1:0]  word_i,
    input  logic                   pop_i,
    output logic [AES_BLOCK_W-1:0] block_o,
    output logic                   full_o
);

    logic [AES_BLOCK_W-1:0] data_q;
    logic                   full_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (load_i) begin
            for (int k = 0; k < AES_BLOCK_WORDS; k++) begin
                if (idx_i == 2'(k)) begin
                    data_q[k*AES_WORD_W +: AES_WORD_W] <= word_i;
                end
            end
        end
    end

    // Clear wins over completing the block so a cleared block is never emitted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
        end else if (clear_i) begin
            full_q <= 1'b0;
        end else if (load_i && (idx_i == 2'd3)) begin
            full_q <= 1'b1;
        end else if (pop_i) begin
            full_q <= 1'b0;
        end
    end

    assign block_o = data_q;
    assign full_o  = full_q;

endmodule

// File: rtl/aes_stream_packer.sv
// Packs four 32-bit stream words into one 128-bit block for the AES engine.
// Defining AES_PACKER_PINGPONG_EN adds a second slot so input keeps flowing.
module aes_stream_packer
    import aes_package::*;
#(
    parameter int unsigned WORD_W      = AES_WORD_W,
    parameter int unsigned BLOCK_WORDS = AES_BLOCK_WORDS,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    hwpe_stream_intf_stream.sink          in_i,
    output logic [WORD_W*BLOCK_WORDS-1:0] block_o,
    output logic                          block_valid_o,
    input  logic                          block_ready_i,
    output logic [1:0]                    word_cnt_o,
    output logic [CNT_W-1:0]              block_cnt_o,
    output logic                          err_strb_o
);

    localparam logic [AES_CNT_W-1:0] CntMask = AES_CNT_W'((33'd1 << CNT_W) - 33'd1);

    packer_state_t state_q, state_d;
    flags_packer_t flags_q, flags_d;

    logic in_hs;
    logic out_hs;
    logic last_word;
    logic other_busy;

    assign in_i.ready = (state_q == FILL);
    assign in_hs      = in_i.valid && in_i.ready;
    assign last_word  = in_hs && (flags_q.word_cnt == 2'd3);
    assign out_hs     = block_valid_o && block_ready_i;

`ifdef AES_PACKER_PINGPONG_EN
    logic                   wr_sel_q, wr_sel_d;
    logic                   rd_sel_q, rd_sel_d;
    logic [1:0]             slot_full;
    logic [AES_BLOCK_W-1:0] slot_data [2];

    for (genvar g = 0; g < 2; g++) begin : gen_slot
        aes_block_slot u_slot (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clear_i (clear_i),
            .load_i  (in_hs && (wr_sel_q == 1'(g))),
            .idx_i   (flags_q.word_cnt),
            .word_i  (in_i.data),
            .pop_i   (out_hs && (rd_sel_q == 1'(g))),
            .block_o (slot_data[g]),
            .full_o  (slot_full[g])
        );
    end

    // Write pointer moves after each completed block, read pointer after each
    // hand-off, which keeps blocks leaving in arrival order.
    always_comb begin
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        if (last_word) wr_sel_d = ~wr_sel_q;
        if (out_hs)    rd_sel_d = ~rd_sel_q;
        if (clear_i) begin
            wr_sel_d = 1'b0;
            rd_sel_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    assign other_busy    = slot_full[~wr_sel_q] && !out_hs;
    assign block_o       = slot_data[rd_sel_q];
    assign block_valid_o = slot_full[rd_sel_q];
`else
    logic                   slot_full;
    logic [AES_BLOCK_W-1:0] slot_data;

    aes_block_slot u_slot (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .load_i  (in_hs),
        .idx_i   (flags_q.word_cnt),
        .word_i  (in_i.data),
        .pop_i   (out_hs),
        .block_o (slot_data),
        .full_o  (slot_full)
    );

    assign other_busy    = 1'b1;
    assign block_o       = slot_data;
    assign block_valid_o = slot_full;
`endif

    // FULL means no slot can take another word; input is stalled until a pop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: if (last_word && other_busy) state_d = FULL;
            FULL: if (out_hs) state_d = FILL;
        endcase
        if (clear_i) state_d = FILL;
    end

    always_comb begin
        flags_d = flags_q;
        if (in_hs) begin
            flags_d.word_cnt = flags_q.word_cnt + 2'd1;
            if (in_i.strb != 4'hF) flags_d.err_strb = 1'b1;
        end
        if (out_hs) flags_d.block_cnt = (flags_q.block_cnt + 1'b1) & CntMask;
        if (clear_i) flags_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FILL;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    assign word_cnt_o  = flags_q.word_cnt;
    assign block_cnt_o = flags_q.block_cnt[CNT_W-1:0];
    assign err_strb_o  = flags_q.err_strb;

endmodule

// File: tb/tb_aes_stream_packer.sv
// Directed bench for the single-slot packer; a narrow block counter keeps the
// wrap check short.
module tb_aes_stream_packer;

    localparam int unsigned CntW = 4;

    logic            clk;
    logic            rstN;
    logic            clear;
    logic [127:0]    blockData;
    logic            blockValid;
    logic            blockReady;
    logic [1:0]      wordCnt;
    logic [CntW-1:0] blockCnt;
    logic            errStrb;

    int testsRun  = 0;
    int testsFail = 0;

    logic [31:0]  words [4];
    logic [127:0] expBlock;
    logic [127:0] heldBlock;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) inS ();

    aes_stream_packer #(.CNT_W(CntW)) dut (
        .clk_i         (clk),
        .rst_ni        (rstN),
        .clear_i       (clear),
        .in_i          (inS),
        .block_o       (blockData),
        .block_valid_o (blockValid),
        .block_ready_i (blockReady),
        .word_cnt_o    (wordCnt),
        .block_cnt_o   (blockCnt),
        .err_strb_o    (errStrb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] data, input logic [3:0] strb);
        inS.valid = 1'b1;
        inS.data  = data;
        inS.strb  = strb;
        step();
        inS.valid = 1'b0;
    endtask

    task automatic sendBlock();
        for (int k = 0; k < 4; k++) applyStimulus(words[k], 4'hF);
    endtask

    initial begin
        rstN       = 1'b0;
        clear      = 1'b0;
        blockReady = 1'b1;
        inS.valid  = 1'b0;
        inS.data   = '0;
        inS.strb   = 4'hF;
        words[0] = 32'h03020100;
        words[1] = 32'h07060504;
        words[2] = 32'h0B0A0908;
        words[3] = 32'h0F0E0D0C;
        expBlock = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
        repeat (3) step();
        rstN = 1'b1;
        step();

        checkOutput("rst_block",  blockData, 128'h0);
        checkOutput("rst_valid",  128'(blockValid), 128'h0);
        checkOutput("rst_wcnt",   128'(wordCnt), 128'h0);
        checkOutput("rst_bcnt",   128'(blockCnt), 128'h0);
        checkOutput("rst_err",    128'(errStrb), 128'h0);
        checkOutput("rst_ready",  128'(inS.ready), 128'h1);

        // Basic block with the engine always ready: one bubble on input.
        applyStimulus(words[0], 4'hF);
        checkOutput("wcnt_after_w0", 128'(wordCnt), 128'h1);
        for (int k = 1; k < 4; k++) applyStimulus(words[k], 4'hF);
        checkOutput("b1_valid", 128'(blockValid), 128'h1);
        checkOutput("b1_data",  blockData, expBlock);
        checkOutput("b1_ready_low", 128'(inS.ready), 128'h0);
        checkOutput("b1_wcnt", 128'(wordCnt), 128'h0);
        step();
        checkOutput("b1_valid_drop", 128'(blockValid), 128'h0);
        checkOutput("b1_ready_back", 128'(inS.ready), 128'h1);
        checkOutput("b1_bcnt", 128'(blockCnt), 128'h1);

        // Backpressure: block held with input stalled for ten cycles.
        blockReady = 1'b0;
        sendBlock();
        heldBlock = blockData;
        for (int c = 0; c < 10; c++) begin
            checkOutput("bp_valid", 128'(blockValid), 128'h1);
            checkOutput("bp_ready", 128'(inS.ready), 128'h0);
            checkOutput("bp_data",  blockData, expBlock);
            if (c < 9) step();
        end
        checkOutput("bp_stable", blockData, heldBlock);
        blockReady = 1'b1;
        step();
        checkOutput("bp_release_valid", 128'(blockValid), 128'h0);
        checkOutput("bp_release_ready", 128'(inS.ready), 128'h1);
        checkOutput("bp_bcnt", 128'(blockCnt), 128'h2);

        // Partial strobe on word 1: flag is sticky, data still packed.
        applyStimulus(words[0], 4'hF);
        checkOutput("strb_err_before", 128'(errStrb), 128'h0);
        applyStimulus(words[1], 4'h7);
        checkOutput("strb_err_set", 128'(errStrb), 128'h1);
        applyStimulus(words[2], 4'hF);
        applyStimulus(words[3], 4'hF);
        checkOutput("strb_block", blockData, expBlock);
        checkOutput("strb_valid", 128'(blockValid), 128'h1);
        step();
        checkOutput("strb_err_sticky", 128'(errStrb), 128'h1);
        checkOutput("strb_bcnt", 128'(blockCnt), 128'h3);
        clear = 1'b1;
        step();
        clear = 1'b0;
        checkOutput("clr_err",  128'(errStrb), 128'h0);
        checkOutput("clr_bcnt", 128'(blockCnt), 128'h0);

        // Async reset after two words discards the partial block.
        applyStimulus(32'hDEADBEEF, 4'hF);
        applyStimulus(32'hCAFEF00D, 4'hF);
        checkOutput("mid_wcnt", 128'(wordCnt), 128'h2);
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_block", blockData, 128'h0);
        checkOutput("mid_rst_wcnt",  128'(wordCnt), 128'h0);
        checkOutput("mid_rst_valid", 128'(blockValid), 128'h0);
        checkOutput("mid_rst_ready", 128'(inS.ready), 128'h1);
        #3;
        rstN = 1'b1;
        step();
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        words[2] = 32'h33333333;
        words[3] = 32'h44444444;
        sendBlock();
        checkOutput("fresh_valid", 128'(blockValid), 128'h1);
        checkOutput("fresh_block", blockData, 128'h44444444_33333333_22222222_11111111);
        step();
        checkOutput("fresh_bcnt", 128'(blockCnt), 128'h1);

        // Clear coinciding with word 3 suppresses the block.
        for (int k = 0; k < 3; k++) applyStimulus(words[k], 4'hF);
        clear = 1'b1;
        applyStimulus(words[3], 4'hF);
        clear = 1'b0;
        checkOutput("clrw3_valid", 128'(blockValid), 128'h0);
        checkOutput("clrw3_wcnt",  128'(wordCnt), 128'h0);
        checkOutput("clrw3_ready", 128'(inS.ready), 128'h1);
        checkOutput("clrw3_bcnt",  128'(blockCnt), 128'h0);
        step();
        checkOutput("clrw3_still_idle", 128'(blockValid), 128'h0);

        // Block counter wrap at 2^CntW.
        for (int b = 0; b < 15; b++) begin
            sendBlock();
            step();
        end
        checkOutput("wrap_pre", 128'(blockCnt), 128'hF);
        sendBlock();
        step();
        checkOutput("wrap_zero", 128'(blockCnt), 128'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
